// File: rtl/demodulator.sv
// QPSK hard-decision demodulator: packs four sign-decided dibits into a byte, symbol 0 marked by in_sig.
// Optional per-byte erasure flag enabled with the DEMOD_ERASURE_EN macro.
module demodulator #(
  parameter int                DATA_W       = 24,
  parameter logic [DATA_W-1:0] ERASE_THRESH = 24'd1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_y,
  input  logic              in_valid,
  input  logic              in_sig,
  output logic [7:0]        out,
  output logic              out_valid,
  output logic              sync_err,
  output logic              out_erase
);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [7:0]  r_byte;
  logic        r_erase;
  logic [7:0]  r_out;
  logic        r_out_valid;
  logic        r_sync_err;
  logic        r_out_erase;

  logic signed [DATA_W-1:0] w_x;
  logic signed [DATA_W-1:0] w_y;
  logic [1:0]               w_dibit;
  logic [7:0]               w_byte_ins;
  logic                     w_erase;

  assign w_x = $signed(in_x);
  assign w_y = $signed(in_y);

  // Only the sign bits matter; bit1 flags differing signs, bit0 is the y sign.
  function automatic logic [1:0] hard_dibit(input logic signed [DATA_W-1:0] x,
                                            input logic signed [DATA_W-1:0] y);
    return {x[DATA_W-1] ^ y[DATA_W-1], y[DATA_W-1]};
  endfunction

  assign w_dibit = hard_dibit(w_x, w_y);

  always_comb begin
    w_byte_ins = r_byte;
    w_byte_ins[{r_cnt, 1'b0} +: 2] = w_dibit;
  end

`ifdef DEMOD_ERASURE_EN
  // Most-negative input has no positive twin; clamp it to the largest magnitude.
  function automatic logic [DATA_W-1:0] mag_sat(input logic signed [DATA_W-1:0] v);
    if (v == $signed({1'b1, {(DATA_W-1){1'b0}}}))
      return {1'b0, {(DATA_W-1){1'b1}}};
    else if (v[DATA_W-1])
      return $unsigned(-v);
    else
      return $unsigned(v);
  endfunction

  assign w_erase = (mag_sat(w_x) < ERASE_THRESH) || (mag_sat(w_y) < ERASE_THRESH);
`else
  logic w_unused_mag;
  assign w_unused_mag = ^{ERASE_THRESH, in_x[DATA_W-2:0], in_y[DATA_W-2:0]};
  assign w_erase = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= 2'd0;
      r_byte      <= 8'h00;
      r_erase     <= 1'b0;
      r_out       <= 8'h00;
      r_out_valid <= 1'b0;
      r_sync_err  <= 1'b0;
      r_out_erase <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_sync_err  <= 1'b0;
      if (in_valid) begin
        case (r_state)
          IDLE: begin
            if (in_sig) begin
              r_byte  <= {6'b0, w_dibit};
              r_erase <= w_erase;
              r_cnt   <= 2'd1;
              r_state <= COLLECT;
            end
          end
          COLLECT: begin
            if (in_sig) begin
              // Early marker: restart the byte with this symbol as symbol 0.
              r_sync_err <= 1'b1;
              r_byte     <= {6'b0, w_dibit};
              r_erase    <= w_erase;
              r_cnt      <= 2'd1;
            end else if (r_cnt == 2'd3) begin
              r_out       <= w_byte_ins;
              r_out_erase <= r_erase | w_erase;
              r_out_valid <= 1'b1;
              r_byte      <= 8'h00;
              r_erase     <= 1'b0;
              r_cnt       <= 2'd0;
              r_state     <= IDLE;
            end else begin
              r_byte  <= w_byte_ins;
              r_erase <= r_erase | w_erase;
              r_cnt   <= r_cnt + 2'd1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign sync_err  = r_sync_err;
`ifdef DEMOD_ERASURE_EN
  assign out_erase = r_out_erase;
`else
  logic w_unused_erase;
  assign w_unused_erase = r_out_erase;
  assign out_erase = 1'b0;
`endif

endmodule

// File: tb/tb_demodulator.sv
// Directed table-driven bench for demodulator: one record per clock, outputs checked after each edge.
module tb_demodulator;

  localparam int DATA_W = 24;
`ifdef DEMOD_ERASURE_EN
  localparam bit ERA = 1'b1;
`else
  localparam bit ERA = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [DATA_W-1:0] in_x = '0;
  logic [DATA_W-1:0] in_y = '0;
  logic              in_valid = 1'b0;
  logic              in_sig = 1'b0;
  logic [7:0]        out;
  logic              out_valid;
  logic              sync_err;
  logic              out_erase;

  int n_assert = 0;
  int n_fail   = 0;

  demodulator #(.DATA_W(DATA_W), .ERASE_THRESH(24'd1)) dut (
    .clk(clk), .reset(reset), .in_x(in_x), .in_y(in_y), .in_valid(in_valid),
    .in_sig(in_sig), .out(out), .out_valid(out_valid), .sync_err(sync_err),
    .out_erase(out_erase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                     rst_n;
    logic signed [DATA_W-1:0] x;
    logic signed [DATA_W-1:0] y;
    logic                     v;
    logic                     s;
    logic [7:0]               o;
    logic                     ov;
    logic                     se;
    logic                     oe;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst_n, int x, int y, logic v, logic s,
                              logic [7:0] o, logic ov, logic se, logic oe);
    vec_t t;
    t.rst_n = rst_n; t.x = DATA_W'(x); t.y = DATA_W'(y); t.v = v; t.s = s;
    t.o = o; t.ov = ov; t.se = se; t.oe = oe;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst_n, input int x, input int y, input logic v, input logic s);
    reset = rst_n; in_x = DATA_W'(x); in_y = DATA_W'(y); in_valid = v; in_sig = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    tbl.push_back(mk(0,  0,  0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0,  1,  1, 1, 1, 8'h00, 0, 0, 0));
    // Contiguous byte E4
    tbl.push_back(mk(1,  1,  1, 1, 1, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, -1, -1, 1, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, -1,  1, 1, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1,  1, -1, 1, 0, 8'hE4, 1, 0, 0));
    tbl.push_back(mk(1,  0,  0, 0, 0, 8'hE4, 0, 0, 0));
    // Early in_sig restarts byte, result 01
    tbl.push_back(mk(1,  1,  1, 1, 1, 8'hE4, 0, 0, 0));
    tbl.push_back(mk(1, -1, -1, 1, 0, 8'hE4, 0, 0, 0));
    tbl.push_back(mk(1, -1, -1, 1, 1, 8'hE4, 0, 1, 0));
    tbl.push_back(mk(1,  1,  1, 1, 0, 8'hE4, 0, 0, 0));
    tbl.push_back(mk(1,  1,  1, 1, 0, 8'hE4, 0, 0, 0));
    tbl.push_back(mk(1,  1,  1, 1, 0, 8'h01, 1, 0, 0));
    // E4 with 3-cycle gaps; invalid cycles carry garbage that must be ignored
    for (int k = 0; k < 4; k++) begin
      int xs [4] = '{1, -1, -1, 1};
      int ys [4] = '{1, -1, 1, -1};
      tbl.push_back(mk(1, xs[k], ys[k], 1, (k == 0), (k == 3) ? 8'hE4 : 8'h01, (k == 3), 0, 0));
      for (int g = 0; g < 3; g++)
        tbl.push_back(mk(1, -7, -7, 0, 1, (k == 3) ? 8'hE4 : 8'h01, 0, 0, 0));
    end
    // Symbols without in_sig while IDLE are dropped
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1, -1, -1, 1, 0, 8'hE4, 0, 0, 0));
    // Reset mid-byte (overrides in_valid), then a lone symbol must not complete it
    tbl.push_back(mk(1, -1,  1, 1, 1, 8'hE4, 0, 0, 0));
    tbl.push_back(mk(1, -1,  1, 1, 0, 8'hE4, 0, 0, 0));
    tbl.push_back(mk(1, -1,  1, 1, 0, 8'hE4, 0, 0, 0));
    tbl.push_back(mk(0, -1,  1, 1, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1,  1, -1, 1, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1,  0,  0, 1, 1, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1,  0,  0, 1, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1,  0,  0, 1, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1,  0,  0, 1, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(1,  0,  0, 0, 0, 8'h00, 0, 0, 0));
    // Erasure byte E0 then back-to-back clean byte B1 (includes most-negative x)
    tbl.push_back(mk(1,     0,     5, 1, 1, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1,  1000,  1000, 1, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, -1000,  1000, 1, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1,  1000, -1000, 1, 0, 8'hE0, 1, 0, ERA));
    tbl.push_back(mk(1, -8388608, -1000, 1, 1, 8'hE0, 0, 0, ERA));
    tbl.push_back(mk(1,  1000,  1000, 1, 0, 8'hE0, 0, 0, ERA));
    tbl.push_back(mk(1,  1000, -1000, 1, 0, 8'hE0, 0, 0, ERA));
    tbl.push_back(mk(1, -1000,  1000, 1, 0, 8'hB1, 1, 0, 0));
    tbl.push_back(mk(1,  0,  0, 0, 0, 8'hB1, 0, 0, 0));

    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      drive(tbl[i].rst_n, int'(tbl[i].x), int'(tbl[i].y), tbl[i].v, tbl[i].s);
      chk("out",       i, out,               tbl[i].o);
      chk("out_valid", i, {7'b0, out_valid}, {7'b0, tbl[i].ov});
      chk("sync_err",  i, {7'b0, sync_err},  {7'b0, tbl[i].se});
      chk("out_erase", i, {7'b0, out_erase}, {7'b0, tbl[i].oe});
    end

    // Erased symbol in a partial byte is forgotten after a sync restart
    drive(1, 0, 5, 1, 1);
    drive(1, 1, 1, 1, 1);
    chk("seq_serr", 100, {7'b0, sync_err}, 8'h01);
    drive(1, -1, -1, 1, 0);
    drive(1, -1, -1, 1, 0);
    drive(1, -1, -1, 1, 0);
    chk("seq_out",   101, out,               8'h54);
    chk("seq_ov",    102, {7'b0, out_valid}, 8'h01);
    chk("seq_erase", 103, {7'b0, out_erase}, 8'h00);

    // Bounded wait: out_valid must be a single pulse, then stay low while idle
    begin
      int pulses = 0;
      drive(1, 1, 1, 1, 1);
      drive(1, 1, 1, 1, 0);
      drive(1, 1, 1, 1, 0);
      for (int c = 0; c < 20; c++) begin
        drive(1, 1, 1, (c == 0), 0);
        if (out_valid) pulses++;
      end
      chk("seq_pulses", 104, 8'(pulses), 8'd1);
      chk("seq_out2",   105, out,        8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/demodulator.md
DEMODULATOR -- requirements
Module: demodulator

Interface
REQ-001 Parameter DATA_W, default 24: width of signed I/Q input samples.
REQ-002 Parameter ERASE_THRESH, default 24'd1: magnitude below which a sample is an erasure; used only under DEMOD_ERASURE_EN.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous active-low reset, sampled on rising clk edge.
REQ-005 in_x  input  DATA_W  signed in-phase sample.
REQ-006 in_y  input  DATA_W  signed quadrature sample.
REQ-007 in_valid  input  1  in_x/in_y carry a symbol this cycle.
REQ-008 in_sig  input  1  qualified by in_valid: this symbol is symbol 0 of a byte.
REQ-009 out  output  8  last assembled byte (registered).
REQ-010 out_valid  output  1  one-cycle pulse: out updated this cycle.
REQ-011 sync_err  output  1  one-cycle pulse: partial byte discarded by an early in_sig.
REQ-012 out_erase  output  1  registered with out: at least one erased sample in the byte.

Function
REQ-013 Symbol accepted only on a cycle with in_valid=1; cycles with in_valid=0 hold all state.
REQ-014 Hard decision on sign bits only; zero counts as non-negative.
REQ-015 Dibit map: x>=0,y>=0 -> 00; x<0,y<0 -> 01; x<0,y>=0 -> 10; x>=0,y<0 -> 11.
REQ-016 Symbol k (k=0..3) lands in byte bits [2k+1:2k]; symbol 0 is LSB dibit.
REQ-017 FSM states IDLE and COLLECT, plus 2-bit symbol index cnt.
REQ-018 IDLE: in_valid&in_sig -> store dibit in bits[1:0], cnt=1, go COLLECT.
REQ-019 IDLE: in_valid&!in_sig -> symbol dropped, no output, no error.
REQ-020 COLLECT: in_valid&!in_sig -> store dibit at cnt, cnt+1; at cnt=3 commit byte and go IDLE.
REQ-021 Commit: out, out_erase loaded and out_valid=1 on the clock edge accepting symbol 3 (latency 1 cycle after symbol 3 presented).
REQ-022 COLLECT: in_valid&in_sig -> sync_err=1 same edge, partial byte and erase flag discarded, symbol taken as new symbol 0, cnt=1, stay COLLECT.
REQ-023 out holds its value between commits; out_valid and sync_err are 0 on every non-event cycle.
REQ-024 Back-to-back bytes with no idle cycles sustained: 1 symbol/cycle, one byte per 4 cycles.

Reset
REQ-025 reset=0 at a rising edge: state IDLE, cnt=0, partial byte=0, out=8'h00, out_valid=0, sync_err=0, out_erase=0.
REQ-026 Reset mid-byte discards partial byte with no out_valid and no sync_err; reset overrides simultaneous in_valid.

Configuration
REQ-027 Macro DEMOD_ERASURE_EN defined: sample erased when |in_x|<ERASE_THRESH or |in_y|<ERASE_THRESH; |-2^(DATA_W-1)| saturates to 2^(DATA_W-1)-1; per-byte sticky flag ORed over 4 symbols, output as out_erase at commit.
REQ-028 Macro DEMOD_ERASURE_EN undefined: out_erase tied 0, no magnitude logic; all other behaviour identical.

Verification
REQ-029 Symbols (1,1)s,(-1,-1),(-1,1),(1,-1) contiguous, in_sig on first -> out=8'hE4, out_valid one cycle after 4th symbol.
REQ-030 Same byte with in_valid=0 gaps of 3 cycles between symbols -> out=8'hE4, exactly one out_valid pulse.
REQ-031 Two symbols then in_sig with (-1,-1),(1,1),(1,1),(1,1) -> sync_err pulse on 3rd symbol, then out=8'h01.
REQ-032 Symbols with in_sig=0 while IDLE -> no out_valid, no sync_err, out unchanged.
REQ-033 reset=0 after 3 symbols, then full byte (0,0)x4 -> out=8'h00 from new byte only, out_valid once.
REQ-034 DEMOD_ERASURE_EN, ERASE_THRESH=1: byte containing sample (0,5) -> out_erase=1; next byte of all (+/-1000) -> out_erase=0; without macro out_erase=0 for both.
